// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg: shared widths, opcodes, flag indices and sequencer states. Rev 1.0
// ============================================================================
package alu_pkg;

  localparam int W     = 20;
  localparam int HW    = 10;
  localparam int CW    = 5;
  localparam int Z_BIT = 0;
  localparam int S_BIT = 1;
  localparam int C_BIT = 2;

  typedef enum logic [4:0] {
    OP_NOP   = 5'd0,
    OP_NOT   = 5'd1,
    OP_AND   = 5'd2,
    OP_OR    = 5'd3,
    OP_XOR   = 5'd4,
    OP_SHL   = 5'd5,
    OP_SHR   = 5'd6,
    OP_ROL   = 5'd7,
    OP_ROR   = 5'd8,
    OP_INC   = 5'd9,
    OP_DEC   = 5'd10,
    OP_ADD   = 5'd11,
    OP_ADC   = 5'd12,
    OP_SUB   = 5'd13,
    OP_SBC   = 5'd14,
    OP_CMP   = 5'd15,
    OP_LDSR  = 5'd16,
    OP_XORSR = 5'd17
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [W-1:0] width_mask(input logic md);
    return md ? {W{1'b1}} : {{(W-HW){1'b0}}, {HW{1'b1}}};
  endfunction

  function automatic logic active_msb(input logic [W-1:0] v, input logic md);
    return md ? v[W-1] : v[HW-1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_shift_step.sv
`default_nettype none
// ============================================================================
// alu_shift_step: one-bit SHL/SHR/ROL/ROR within the active width. Rev 1.0
// ============================================================================
module alu_shift_step
  import alu_pkg::*;
(
  input  logic [W-1:0] value,
  input  logic         mode,
  input  logic [4:0]   op,
  output logic [W-1:0] step_next,
  output logic         shifted_out
);

  logic [W-1:0] mask;
  logic         msb;
  logic [W-1:0] wrap_top;

  always_comb begin
    mask     = width_mask(mode);
    msb      = active_msb(value, mode);
    // bit 0 re-enters at the active msb position for ROR
    wrap_top = mode ? {value[0], {(W-1){1'b0}}}
                    : {{(W-HW){1'b0}}, value[0], {(HW-1){1'b0}}};
    step_next   = value;
    shifted_out = 1'b0;
    case (opcode_t'(op))
      OP_SHL: begin
        step_next   = (value << 1) & mask;
        shifted_out = msb;
      end
      OP_SHR: begin
        step_next   = (value & mask) >> 1;
        shifted_out = value[0];
      end
      OP_ROL: begin
        step_next   = ((value << 1) | {{(W-1){1'b0}}, msb}) & mask;
        shifted_out = msb;
      end
      OP_ROR: begin
        step_next   = (((value & mask) >> 1) | wrap_top) & mask;
        shifted_out = value[0];
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// alu_sequencer: multi-cycle 20-bit ALU controller owning the {C,S,Z} flags. Rev 1.0
// ============================================================================
module alu_sequencer
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   op,
  input  logic         mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [2:0]   flags,
  output logic         busy
);

  state_t          state, state_n;
  logic [4:0]      op_r;
  logic            mode_r;
  logic [W-1:0]    a_r, b_r, work;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    step_next;
  logic            step_out;
  logic            is_shift;
  logic [W-1:0]    res_c;
  logic [2:0]      flags_c;
  logic [W-1:0]    m, am, bm, v;
  logic [W:0]      add_w, sub_w;
  logic            add_c, sub_c, c, upd;

  function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] n, input logic md);
    logic [CW-1:0] lim;
    lim = md ? CW'(W-1) : CW'(HW-1);
    return (n > lim) ? lim : n;
  endfunction

  alu_shift_step u_step (
    .value       (work),
    .mode        (mode_r),
    .op          (op_r),
    .step_next   (step_next),
    .shifted_out (step_out)
  );

  assign is_shift  = (op_r >= OP_SHL) && (op_r <= OP_ROR);
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (in_valid) state_n = ST_EXEC;
      ST_EXEC: if (!is_shift || cnt <= CW'(1)) state_n = ST_DONE;
      ST_DONE: if (out_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Carry/borrow is read one bit above the active msb of the extended sum.
  always_comb begin
    m     = width_mask(mode_r);
    am    = a_r & m;
    bm    = b_r & m;
    add_w = {1'b0, am} + {1'b0, (op_r == OP_INC) ? W'(1) : bm}
          + {{W{1'b0}}, (op_r == OP_ADC) & flags[C_BIT]};
    sub_w = {1'b0, am} - {1'b0, (op_r == OP_DEC) ? W'(1) : bm}
          - {{W{1'b0}}, (op_r == OP_SBC) & flags[C_BIT]};
    add_c = mode_r ? add_w[W] : add_w[HW];
    sub_c = mode_r ? sub_w[W] : sub_w[HW];

    v       = '0;
    c       = 1'b0;
    upd     = 1'b0;
    res_c   = '0;
    flags_c = flags;
    case (opcode_t'(op_r))
      OP_NOT: begin v = ~am;     upd = 1'b1; end
      OP_AND: begin v = am & bm; upd = 1'b1; end
      OP_OR:  begin v = am | bm; upd = 1'b1; end
      OP_XOR: begin v = am ^ bm; upd = 1'b1; end
      OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
        v   = (cnt == '0) ? work : step_next;
        c   = (cnt != '0) & step_out;
        upd = 1'b1;
      end
      OP_INC, OP_ADD, OP_ADC: begin v = add_w[W-1:0]; c = add_c; upd = 1'b1; end
      OP_DEC, OP_SUB, OP_SBC: begin v = sub_w[W-1:0]; c = sub_c; upd = 1'b1; end
      OP_CMP: begin
        res_c          = am;
        flags_c[Z_BIT] = ((sub_w[W-1:0] & m) == '0);
        flags_c[S_BIT] = active_msb(sub_w[W-1:0], mode_r);
        flags_c[C_BIT] = sub_c;
      end
      OP_LDSR: begin
        flags_c = a_r[2:0];
        res_c   = {{(W-3){1'b0}}, a_r[2:0]};
      end
      OP_XORSR: begin
        flags_c = flags ^ a_r[2:0];
        res_c   = {{(W-3){1'b0}}, flags ^ a_r[2:0]};
      end
      default: ;
    endcase
    if (upd) begin
      res_c          = v & m;
      flags_c[Z_BIT] = (res_c == '0);
      flags_c[S_BIT] = active_msb(res_c, mode_r);
      flags_c[C_BIT] = c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r   <= '0;
      mode_r <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      work   <= '0;
      cnt    <= '0;
      result <= '0;
      flags  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          op_r   <= op;
          mode_r <= mode;
          a_r    <= a;
          b_r    <= b;
          work   <= a & width_mask(mode);
          cnt    <= clamp_count(b[CW-1:0], mode);
        end
        ST_EXEC: begin
          if (is_shift && cnt > CW'(1)) begin
            work <= step_next;
            cnt  <= cnt - CW'(1);
          end
          if (state_n == ST_DONE) begin
            result <= res_c;
            flags  <= flags_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_alu_sequencer: directed vectors with hand-computed results and flags. Rev 1.0
// ============================================================================
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  op;
  logic        mode;
  logic [19:0] a, b;
  logic        out_valid, out_ready;
  logic [19:0] result;
  logic [2:0]  flags;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] o, input logic md,
                        input logic [19:0] va, input logic [19:0] vb,
                        input logic [19:0] er, input logic [2:0] ef,
                        input int elat, input int hold);
    int lat;
    @(negedge clk);
    op = o; mode = md; a = va; b = vb; in_valid = 1'b1;
    check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    a = 20'h0; b = 20'h0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      check({tag, "/busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      lat++;
    end
    check({tag, "/out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "/result"}, 32'(result), 32'(er));
    check({tag, "/flags"}, 32'(flags), 32'(ef));
    if (elat > 0) check({tag, "/latency"}, 32'(lat), 32'(elat));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "/hold_result"}, 32'(result), 32'(er));
      check({tag, "/hold_flags"}, 32'(flags), 32'(ef));
      check({tag, "/hold_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "/valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "/idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 5'd0; mode = 1'b0; a = 20'h0; b = 20'h0;
    @(negedge clk);
    check("reset/in_ready", 32'(in_ready), 32'd1);
    check("reset/out_valid", 32'(out_valid), 32'd0);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/result", 32'(result), 32'd0);
    check("reset/flags", 32'(flags), 32'd0);
    rst = 1'b0;

    run_op("add_full",  5'd11, 1'b1, 20'hFFFFF, 20'h00001, 20'h00000, 3'b101, 2, 0);
    run_op("shl_full",  5'd5,  1'b1, 20'h80001, 20'h00003, 20'h00008, 3'b000, 4, 0);
    run_op("ror_half",  5'd8,  1'b0, 20'h00001, 20'h00001, 20'h00200, 3'b110, 2, 5);
    run_op("ldsr",      5'd16, 1'b1, 20'h00005, 20'h00000, 20'h00005, 3'b101, 2, 0);
    run_op("adc",       5'd12, 1'b1, 20'h00001, 20'h00001, 20'h00003, 3'b000, 2, 0);
    run_op("sub_half",  5'd13, 1'b0, 20'hFFC05, 20'h00006, 20'h003FF, 3'b110, 2, 0);

    // abort a 10-step shift with an asynchronous reset in its third cycle
    @(negedge clk);
    op = 5'd5; mode = 1'b1; a = 20'h12345; b = 20'h0000A; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort/out_valid", 32'(out_valid), 32'd0);
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/in_ready", 32'(in_ready), 32'd1);
    check("abort/flags", 32'(flags), 32'd0);
    check("abort/result", 32'(result), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("and_full",  5'd2,  1'b1, 20'hF0F0F, 20'h0FF00, 20'h00F00, 3'b000, 2, 0);
    run_op("ldsr6",     5'd16, 1'b1, 20'h00006, 20'h00000, 20'h00006, 3'b110, 0, 0);
    run_op("nop",       5'd0,  1'b1, 20'h12345, 20'h54321, 20'h00000, 3'b110, 2, 0);
    run_op("xorsr",     5'd17, 1'b1, 20'h00003, 20'h00000, 20'h00005, 3'b101, 0, 0);
    run_op("cmp_eq",    5'd15, 1'b1, 20'h00005, 20'h00005, 20'h00005, 3'b001, 0, 0);
    run_op("illegal",   5'd20, 1'b1, 20'hABCDE, 20'h12345, 20'h00000, 3'b001, 2, 0);
    run_op("shr_clamp", 5'd6,  1'b0, 20'h003FF, 20'h0001F, 20'h00001, 3'b100, 10, 0);
    run_op("rol_zero",  5'd7,  1'b1, 20'h80000, 20'h00000, 20'h80000, 3'b010, 2, 0);
    run_op("sub_borrow",5'd13, 1'b1, 20'h00000, 20'h00001, 20'hFFFFF, 3'b110, 0, 0);
    run_op("sbc",       5'd14, 1'b1, 20'h00010, 20'h00003, 20'h0000C, 3'b000, 0, 0);
    run_op("dec_zero",  5'd10, 1'b1, 20'h00000, 20'h00000, 20'hFFFFF, 3'b110, 0, 0);
    run_op("inc_half",  5'd9,  1'b0, 20'h003FF, 20'h00000, 20'h00000, 3'b101, 0, 0);
    run_op("not_half",  5'd1,  1'b0, 20'hFFC0F, 20'h00000, 20'h003F0, 3'b010, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
